out_fm_tile_scheduler: RTL and testbench

OUT_FM_TILE_SCHEDULER -- requirements
Module: out_fm_tile_scheduler

---
 rtl/out_fm_pkg.sv | 35 +++
 rtl/out_fm_tile_iter.sv | 93 +++++++++
 rtl/out_fm_tile_scheduler.sv | 117 +++++++++++
 tb/tb_out_fm_tile_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/out_fm_pkg.sv
// Shared types and step helpers for the output feature-map tile scheduler.
// Step functions derive tile strides from layer and tile geometry.
package out_fm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_BUSY       = 3'd3,
        ST_CLEAN      = 3'd4,
        ST_DONE       = 3'd5
    } state_e;

    // Largest multiple of the stride that still leaves room for the kernel
    function automatic int calc_step(input int t, input int s, input int k);
        return ((t + s - k) / s) * s;
    endfunction

    function automatic int col_step(input int tc, input int s, input int k);
        return calc_step(tc, s, k);
    endfunction

    function automatic int row_step(input int tr, input int s, input int k);
        return calc_step(tr, s, k);
    endfunction

    function automatic int c_step(input int c, input int s, input int k);
        return calc_step(c, s, k);
    endfunction

    function automatic int r_step(input int r, input int s, input int k);
        return calc_step(r, s, k);
    endfunction

endpackage

// File: rtl/out_fm_tile_iter.sv
// Tile base iterator: col innermost, then row, then channel.
// Holds the last tile's bases once the final tile has been reached.
module out_fm_tile_iter
    import out_fm_pkg::*;
#(
    parameter int AW       = 16,
    parameter int N        = 32,
    parameter int TN       = 8,
    parameter int COL_STEP = 6,
    parameter int ROW_STEP = 14,
    parameter int C_STEP   = 30,
    parameter int R_STEP   = 62
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic          clear,
    output logic [AW-1:0] base_n,
    output logic [AW-1:0] base_row,
    output logic [AW-1:0] base_col,
    output logic          last
);

    // One extra bit so that base + step never wraps before the compare
    typedef logic [AW:0] sum_t;

    localparam sum_t COL_INC = sum_t'(COL_STEP);
    localparam sum_t ROW_INC = sum_t'(ROW_STEP);
    localparam sum_t N_INC   = sum_t'(TN);
    localparam sum_t COL_LIM = sum_t'(C_STEP);
    localparam sum_t ROW_LIM = sum_t'(R_STEP);
    localparam sum_t N_LIM   = sum_t'(N);

    logic [AW-1:0] col_q, col_d;
    logic [AW-1:0] row_q, row_d;
    logic [AW-1:0] n_q, n_d;

    sum_t col_sum, row_sum, n_sum;
    logic col_wrap, row_wrap, n_wrap;

    // Candidate next bases and their wrap conditions
    always_comb begin
        col_sum  = {1'b0, col_q} + COL_INC;
        row_sum  = {1'b0, row_q} + ROW_INC;
        n_sum    = {1'b0, n_q} + N_INC;
        col_wrap = (col_sum >= COL_LIM);
        row_wrap = (row_sum >= ROW_LIM);
        n_wrap   = (n_sum >= N_LIM);
        last     = col_wrap && row_wrap && n_wrap;
    end

    // Advance one tile on step; the final tile is held for observation
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        n_d   = n_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
            n_d   = '0;
        end else if (step && !last) begin
            if (!col_wrap) begin
                col_d = col_sum[AW-1:0];
            end else begin
                col_d = '0;
                if (!row_wrap) begin
                    row_d = row_sum[AW-1:0];
                end else begin
                    row_d = '0;
                    n_d   = n_sum[AW-1:0];
                end
            end
        end
    end

    // Base registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
            n_q   <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            n_q   <= n_d;
        end
    end

    assign base_n   = n_q;
    assign base_row = row_q;
    assign base_col = col_q;

endmodule

// File: rtl/out_fm_tile_scheduler.sv
// Output feature-map tile scheduler: hands each finished tile to the
// FIFO-to-RAM mover and walks the tile bases across the whole layer.
module out_fm_tile_scheduler
    import out_fm_pkg::*;
#(
    parameter int AW = 16,
    parameter int N  = 32,
    parameter int R  = 64,
    parameter int C  = 32,
    parameter int K  = 3,
    parameter int S  = 1,
    parameter int Tn = 8,
    parameter int Tr = 16,
    parameter int Tc = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          done,
    output logic          busy,
    input  logic          tile_ready,
    output logic          tile_start,
    input  logic          tile_done,
    output logic          conv_tile_clean,
    output logic [AW-1:0] tile_base_n,
    output logic [AW-1:0] tile_base_row,
    output logic [AW-1:0] tile_base_col
);

    localparam int COL_STEP = col_step(Tc, S, K);
    localparam int ROW_STEP = row_step(Tr, S, K);
    localparam int C_STEP   = c_step(C, S, K);
    localparam int R_STEP   = r_step(R, S, K);

    // Degenerate geometry would make the iterator never advance
    if (COL_STEP <= 0 || ROW_STEP <= 0 || C_STEP <= 0 || R_STEP <= 0) begin : g_bad_step
        $error("out_fm_tile_scheduler: non-positive tile step");
    end

    state_e state_q, state_d;

    logic done_q, done_d;
    logic busy_q, busy_d;
    logic start_q, start_d;
    logic clean_q, clean_d;

    logic iter_step;
    logic iter_clear;
    logic iter_last;

    assign iter_clear = (state_q == ST_IDLE) && start;
    assign iter_step  = (state_q == ST_CLEAN);

    out_fm_tile_iter #(
        .AW       (AW),
        .N        (N),
        .TN       (Tn),
        .COL_STEP (COL_STEP),
        .ROW_STEP (ROW_STEP),
        .C_STEP   (C_STEP),
        .R_STEP   (R_STEP)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .step     (iter_step),
        .clear    (iter_clear),
        .base_n   (tile_base_n),
        .base_row (tile_base_row),
        .base_col (tile_base_col),
        .last     (iter_last)
    );

    // Layer sequencing: wait for results, hand off, wait for mover, clean
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:       if (start) state_d = ST_WAIT_READY;
            ST_WAIT_READY: if (tile_ready) state_d = ST_ISSUE;
            ST_ISSUE:      state_d = ST_BUSY;
            ST_BUSY:       if (tile_done) state_d = ST_CLEAN;
            ST_CLEAN:      state_d = iter_last ? ST_DONE : ST_WAIT_READY;
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered copies of the next-state decode
    always_comb begin
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
        start_d = (state_d == ST_ISSUE);
        clean_d = (state_d == ST_CLEAN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            clean_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            clean_q <= clean_d;
        end
    end

    assign done            = done_q;
    assign busy            = busy_q;
    assign tile_start      = start_q;
    assign conv_tile_clean = clean_q;

endmodule

// File: tb/tb_out_fm_tile_scheduler.sv
// Randomized directed bench for out_fm_tile_scheduler.
// Expected tile order comes from nested loops over the layer geometry.
module tb_out_fm_tile_scheduler;

    localparam int AW = 16;

    typedef struct {
        int n;
        int row;
        int col;
    } tile_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic start = 1'b0;
    logic tile_ready = 1'b0;
    logic tile_done = 1'b0;
    logic done, busy, tile_start, conv_tile_clean;
    logic [AW-1:0] tile_base_n, tile_base_row, tile_base_col;

    logic start2 = 1'b0;
    logic ready2 = 1'b1;
    logic tdone2 = 1'b0;
    logic done2, busy2, tstart2, clean2;
    logic [AW-1:0] bn2, br2, bc2;

    int total = 0;
    int bad = 0;
    int n_starts = 0;
    int n_dones = 0;
    int n_starts2 = 0;

    tile_t exp_q[$];
    tile_t exp2_q[$];

    always #5 clk = ~clk;

    out_fm_tile_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .done            (done),
        .busy            (busy),
        .tile_ready      (tile_ready),
        .tile_start      (tile_start),
        .tile_done       (tile_done),
        .conv_tile_clean (conv_tile_clean),
        .tile_base_n     (tile_base_n),
        .tile_base_row   (tile_base_row),
        .tile_base_col   (tile_base_col)
    );

    out_fm_tile_scheduler #(
        .N(8), .R(16), .C(16), .K(3), .S(1), .Tn(8), .Tr(16), .Tc(16)
    ) dut2 (
        .clk             (clk),
        .rst             (rst),
        .start           (start2),
        .done            (done2),
        .busy            (busy2),
        .tile_ready      (ready2),
        .tile_start      (tstart2),
        .tile_done       (tdone2),
        .conv_tile_clean (clean2),
        .tile_base_n     (bn2),
        .tile_base_row   (br2),
        .tile_base_col   (bc2)
    );

    always @(negedge clk) begin
        if (tile_start === 1'b1) n_starts++;
        if (done === 1'b1) n_dones++;
        if (tstart2 === 1'b1) n_starts2++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference tile list from the layer rules
    task automatic build(input int nn, input int rr, input int cc, input int k,
                         input int s, input int tn, input int tr, input int tc);
        int cs, rs, cst, rst_;
        cst = ((tc + s - k) / s) * s;
        rst_ = ((tr + s - k) / s) * s;
        cs = ((cc + s - k) / s) * s;
        rs = ((rr + s - k) / s) * s;
        exp_q.delete();
        for (int n = 0; n < nn; n += tn)
            for (int r = 0; r < rs; r += rst_)
                for (int c = 0; c < cs; c += cst)
                    exp_q.push_back('{n: n, row: r, col: c});
    endtask

    task automatic chk_bases(input string tag, input tile_t t);
        chk({tag, "_n"}, tile_base_n, t.n);
        chk({tag, "_row"}, tile_base_row, t.row);
        chk({tag, "_col"}, tile_base_col, t.col);
    endtask

    // One layer on the default instance; abort_at >= 0 resets mid-tile
    task automatic run_layer(input int abort_at, input int first_wait);
        int s0, d0, d, lat;
        s0 = n_starts;
        d0 = n_dones;
        tile_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < exp_q.size(); i++) begin
            d = (i == 0) ? first_wait : $urandom_range(0, 3);
            if (i == 5) d = 3;
            for (int j = 0; j < d; j++) begin
                tile_done = (i == 5);
                tick();
                chk("no_start_wait", tile_start, 0);
            end
            tile_done = 1'b0;
            tile_ready = 1'b1;
            tick();
            chk("issue", tile_start, 1);
            chk_bases("issue", exp_q[i]);
            if (i == abort_at) begin
                #2 rst = 1'b0;
                #1;
                chk("rst_done", done, 0);
                chk("rst_busy", busy, 0);
                chk("rst_tstart", tile_start, 0);
                chk("rst_clean", conv_tile_clean, 0);
                chk("rst_bases", {tile_base_n, tile_base_row, tile_base_col}, 0);
                tile_ready = 1'b0;
                tick();
                rst = 1'b1;
                chk("abort_no_done", n_dones - d0, 0);
                return;
            end
            tile_ready = $urandom_range(0, 1);
            lat = (i == 7) ? 4 : $urandom_range(1, 5);
            for (int j = 0; j < lat; j++) begin
                start = (i == 7 && j == 2);
                tick();
                start = 1'b0;
                chk("no_extra_start", tile_start, 0);
            end
            tile_done = 1'b1;
            tick();
            chk("clean", conv_tile_clean, 1);
            chk_bases("clean", exp_q[i]);
            tile_done = 1'b0;
            tile_ready = 1'b0;
            if (i < exp_q.size() - 1) begin
                tick();
                chk("clean_once", conv_tile_clean, 0);
                chk("busy_mid", busy, 1);
                chk("no_early_done", done, 0);
            end
        end
        tick();
        chk("done", done, 1);
        chk("busy_at_done", busy, 1);
        tick();
        chk("done_once", done, 0);
        chk("idle_busy", busy, 0);
        chk_bases("hold", exp_q[exp_q.size() - 1]);
        chk("tile_count", n_starts - s0, exp_q.size());
        chk("done_count", n_dones - d0, 1);
    endtask

    initial begin
        build(32, 64, 32, 3, 1, 8, 16, 8);
        repeat (3) tick();
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_tstart", tile_start, 0);
        chk("reset_clean", conv_tile_clean, 0);
        chk("reset_bases", {tile_base_n, tile_base_row, tile_base_col}, 0);
        rst = 1'b1;
        tick();

        tile_done = 1'b1;
        repeat (2) tick();
        chk("idle_ignores_done", busy, 0);
        tile_done = 1'b0;

        run_layer(-1, 20);
        repeat (2) tick();
        run_layer(37, 0);
        repeat (2) tick();
        run_layer(-1, 0);

        build(8, 16, 16, 3, 1, 8, 16, 16);
        exp2_q = exp_q;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        chk("s_issue", tstart2, 1);
        chk("s_n", bn2, exp2_q[0].n);
        chk("s_row", br2, exp2_q[0].row);
        chk("s_col", bc2, exp2_q[0].col);
        repeat (3) tick();
        tdone2 = 1'b1;
        tick();
        chk("s_clean", clean2, 1);
        tdone2 = 1'b0;
        tick();
        chk("s_done", done2, 1);
        chk("s_clean_once", clean2, 0);
        tick();
        chk("s_idle", busy2, 0);
        chk("s_count", n_starts2, exp2_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
